// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, status register
// field positions and the baud divider helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int RX_DATA_LSB = 0;
  localparam int RX_FLAG_BIT = 8;
  localparam int RX_OVR_BIT  = 9;
  localparam int RX_FERR_BIT = 10;

  function automatic int baud_div(
    input int clk_freq,
    input int baud,
    input int ovs
  );
    return clk_freq / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks,
// realigned to zero phase by restart.
module uart_baud_tick_gen #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (restart) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_register_encoder.sv
// UART receiver: deserialises rx and packs data plus status
// flags into the processor-visible 32-bit Rx register.
module uart_rx_register_encoder
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        clr_rx_flag,
  output logic [31:0] UART_Rx_Reg,
  output logic        rx_flag,
  output logic        busy
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  logic [1:0]    sync_q;
  logic          rxs;
  rx_state_e     state_q;
  logic [OW-1:0] ovs_q;
  logic [BW-1:0] bit_q;
  logic [7:0]    shift_q;
  logic          arm_q;
  logic          busy_q;
  logic          load_q;
  logic          pend_fe_q;
  logic [7:0]    data_q;
  logic          flag_q;
  logic          ovr_q;
  logic          fe_q;
  logic          tick;
  logic          restart;

  assign rxs = sync_q[1];
  // arm_q blocks re-triggering on a line still held low (break)
  assign restart = (state_q == IDLE) && !rxs && arm_q;

  uart_baud_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ovs_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      arm_q     <= 1'b1;
      busy_q    <= 1'b0;
      load_q    <= 1'b0;
      pend_fe_q <= 1'b0;
    end else begin
      load_q <= 1'b0;
      if (rxs) arm_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (restart) begin
            state_q <= START;
            ovs_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (ovs_q == OW'(OVERSAMPLE / 2 - 1)) begin
              ovs_q <= '0;
              if (rxs) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= DATA;
                bit_q   <= '0;
                shift_q <= '0;
              end
            end else begin
              ovs_q <= ovs_q + OW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (ovs_q == OW'(OVERSAMPLE - 1)) begin
              ovs_q          <= '0;
              shift_q[bit_q] <= rxs;
              if (bit_q == BW'(DATA_BITS - 1)) begin
                state_q <= STOP;
              end else begin
                bit_q <= bit_q + BW'(1);
              end
            end else begin
              ovs_q <= ovs_q + OW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (ovs_q == OW'(OVERSAMPLE - 1)) begin
              ovs_q     <= '0;
              load_q    <= 1'b1;
              pend_fe_q <= !rxs;
              state_q   <= IDLE;
              busy_q    <= 1'b0;
              if (!rxs) arm_q <= 1'b0;
            end else begin
              ovs_q <= ovs_q + OW'(1);
            end
          end
        end
      endcase
    end
  end

  // a load beats a coincident clear; overrun only if unacknowledged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      flag_q <= 1'b0;
      ovr_q  <= 1'b0;
      fe_q   <= 1'b0;
    end else if (load_q) begin
      data_q <= shift_q;
      flag_q <= 1'b1;
      ovr_q  <= flag_q && !clr_rx_flag;
      fe_q   <= pend_fe_q;
    end else if (clr_rx_flag && flag_q) begin
      flag_q <= 1'b0;
      ovr_q  <= 1'b0;
      fe_q   <= 1'b0;
    end
  end

  always_comb begin
    UART_Rx_Reg = '0;
    UART_Rx_Reg[RX_DATA_LSB +: 8] = data_q;
    UART_Rx_Reg[RX_FLAG_BIT]      = flag_q;
    UART_Rx_Reg[RX_OVR_BIT]       = ovr_q;
    UART_Rx_Reg[RX_FERR_BIT]      = fe_q;
  end

  assign rx_flag = flag_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_register_encoder.sv
// Scoreboard bench: stimulus queues expected register values,
// a monitor compares them whenever the register changes.
module tb_uart_rx_register_encoder;

  localparam int BIT  = 432;
  localparam int LAT  = 4109;

  typedef struct {
    logic [31:0] val;
    int          at;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rx;
  logic        clr_rx_flag;
  logic [31:0] UART_Rx_Reg;
  logic        rx_flag;
  logic        busy;

  int          cyc;
  int          n_vec;
  int          n_bad;
  bit          mon_en;
  logic [31:0] prev;
  exp_t        q[$];

  uart_rx_register_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .clr_rx_flag(clr_rx_flag),
    .UART_Rx_Reg(UART_Rx_Reg),
    .rx_flag    (rx_flag),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @cyc %0d",
               nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && (UART_Rx_Reg !== prev)) begin
      exp_t e;
      prev = UART_Rx_Reg;
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_change: got %h expected none @cyc %0d",
                 UART_Rx_Reg, cyc);
      end else begin
        e = q.pop_front();
        chk("reg", UART_Rx_Reg, e.val);
        chk("rx_flag", {31'b0, rx_flag}, {31'b0, e.val[8]});
        if (e.at >= 0) chk("latency", cyc, e.at);
      end
    end
  end

  task automatic send_byte(input logic [7:0] d,
                           input logic stopb,
                           input logic [31:0] expv,
                           input bit push);
    int st;
    @(negedge clk);
    st = cyc;
    if (push) q.push_back('{val: expv, at: st + LAT});
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stopb;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_clr(input logic [31:0] expv);
    @(negedge clk);
    q.push_back('{val: expv, at: cyc + 1});
    clr_rx_flag = 1'b1;
    @(negedge clk);
    clr_rx_flag = 1'b0;
  endtask

  initial begin
    bit seen;
    int n;
    n_vec = 0;
    n_bad = 0;
    mon_en = 1'b0;
    prev = 32'h0;
    rx = 1'b1;
    clr_rx_flag = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;

    // 1: reset held while rx toggles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx = 1'($urandom_range(0, 1));
      chk("rst_reg", UART_Rx_Reg, 32'h0);
      chk("rst_flag", {31'b0, rx_flag}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
    end
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    mon_en = 1'b1;

    // 2: clean frame
    send_byte(8'hA5, 1'b1, 32'h0000_01A5, 1'b1);
    chk("t2_busy", {31'b0, busy}, 32'h0);
    chk("t2_flag", {31'b0, rx_flag}, 32'h1);
    pulse_clr(32'h0000_00A5);
    repeat (20) @(negedge clk);

    // 3: short glitch rejected
    seen = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    for (int i = 0; i < 81; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    rx = 1'b1;
    chk("t3_busy_seen", {31'b0, seen}, 32'h1);
    repeat (400) @(negedge clk);
    chk("t3_busy", {31'b0, busy}, 32'h0);
    chk("t3_reg", UART_Rx_Reg, 32'h0000_00A5);
    chk("t3_flag", {31'b0, rx_flag}, 32'h0);

    // 4: framing error
    send_byte(8'h3C, 1'b0, 32'h0000_053C, 1'b1);
    repeat (20) @(negedge clk);

    // break: one error frame, then no restart while low
    @(negedge clk);
    q.push_back('{val: 32'h0000_0700, at: cyc + LAT});
    rx = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("brk_busy", {31'b0, busy}, 32'h0);
    pulse_clr(32'h0000_0000);
    repeat (12 * BIT) @(negedge clk);
    chk("brk_idle", {31'b0, busy}, 32'h0);
    rx = 1'b1;
    repeat (20) @(negedge clk);

    // 5: overrun then clear
    send_byte(8'h11, 1'b1, 32'h0000_0111, 1'b1);
    send_byte(8'h22, 1'b1, 32'h0000_0322, 1'b1);
    pulse_clr(32'h0000_0022);
    repeat (20) @(negedge clk);

    // 6a: clear coincident with load
    send_byte(8'h77, 1'b1, 32'h0000_0177, 1'b1);
    fork
      send_byte(8'h5A, 1'b1, 32'h0000_015A, 1'b1);
      begin
        @(negedge clk);
        repeat (LAT - 1) @(negedge clk);
        clr_rx_flag = 1'b1;
        @(negedge clk);
        clr_rx_flag = 1'b0;
      end
    join
    repeat (20) @(negedge clk);

    // 6b: reset during bit 4, then clean frame
    fork
      send_byte(8'hF3, 1'b1, 32'h0, 1'b0);
      begin
        @(negedge clk);
        repeat (5 * BIT + BIT / 2) @(negedge clk);
        q.push_back('{val: 32'h0, at: -1});
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6b_busy", {31'b0, busy}, 32'h0);
        rst = 1'b1;
      end
    join
    repeat (50) @(negedge clk);
    send_byte(8'h81, 1'b1, 32'h0000_0181, 1'b1);
    repeat (100) @(negedge clk);

    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
